// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing and overrun errors are reported as one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLOCK_HZ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iRX,
  output logic [7:0]               oData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oFramingError,
  output logic                     oOverrun
);

  localparam int B     = CLOCK_HZ / BAUD;
  localparam int H     = B / 2;
  localparam int CNT_W = $clog2(B);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(B - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(H - 1);
  localparam logic [CW-1:0]    FULL_COUNT  = CW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  logic rx_meta_reg;
  logic rxs_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= iRX;
      rxs_reg     <= rx_meta_reg;
    end
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic             push_req;
  logic             frame_err;
  logic             baud_expired;

  assign baud_expired = (cnt_reg == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    push_req     = 1'b0;
    frame_err    = 1'b0;

    if (!baud_expired) begin
      cnt_next = cnt_reg - 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (!rxs_reg) begin
          cnt_next   = HALF_RELOAD;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_expired) begin
          if (rxs_reg) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next     = BIT_RELOAD;
            bit_idx_next = '0;
            state_next   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (baud_expired) begin
          shift_next   = {rxs_reg, shift_reg[7:1]};
          cnt_next     = BIT_RELOAD;
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets the next start edge be caught immediately.
        if (baud_expired) begin
          if (rxs_reg) begin
            push_req   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs_reg) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FIFO: circular buffer of per-entry registers with a combinational head.
  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [DEPTH-1:0] entry_we;
  logic          fifo_full;
  logic          pop;
  logic          push_en;
  logic          overrun_next;
  logic          frame_err_reg;
  logic          overrun_reg;

  assign fifo_full = (count_reg == FULL_COUNT);
  assign pop       = oValid && iReady;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
  assign push_en      = push_req && (!fifo_full || pop);
  assign overrun_next = push_req && fifo_full && !pop;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
    assign entry_we[gi] = push_en && (wr_ptr_reg == AW'(gi));
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem_reg[i] <= shift_reg;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      frame_err_reg <= frame_err;
      overrun_reg   <= overrun_next;
    end
  end

  assign oValid        = (count_reg != '0);
  assign oData         = oValid ? mem_reg[rd_ptr_reg] : 8'h00;
  assign oCount        = count_reg;
  assign oFramingError = frame_err_reg;
  assign oOverrun      = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with B=10, H=5, DEPTH=4.
// Each scenario task drives frames bit by bit and checks outputs inline.
module tb_uart_rx_fifo;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iRX;
  logic       iReady;
  logic [7:0] oData;
  logic       oValid;
  logic [2:0] oCount;
  logic       oFramingError;
  logic       oOverrun;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  uart_rx_fifo #(
    .CLOCK_HZ(1000000),
    .BAUD    (100000),
    .DEPTH   (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iRX          (iRX),
    .oData        (oData),
    .oValid       (oValid),
    .iReady       (iReady),
    .oCount       (oCount),
    .oFramingError(oFramingError),
    .oOverrun     (oOverrun)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (oFramingError === 1'b1) fe_cnt <= fe_cnt + 1;
    if (oOverrun === 1'b1)      ov_cnt <= ov_cnt + 1;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One 100-cycle frame; optionally raises iReady for exactly the push cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic pop_at_push);
    iRX = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      iRX = d[i];
      repeat (10) tick();
    end
    iRX = stop_bit;
    repeat (7) tick();
    if (pop_at_push) begin
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
    end else begin
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; iRX = 1'b1; iReady = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", oCount); end
    n_checks++; if (oData !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", oData); end
    n_checks++; if ({oFramingError, oOverrun} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {oFramingError, oOverrun}); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    int fe0, ov0;
    d = 8'h55; fe0 = fe_cnt; ov0 = ov_cnt;
    iRX = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      iRX = d[i];
      repeat (10) tick();
    end
    iRX = 1'b1;
    repeat (7) tick();
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", oValid); end
    tick();
    n_checks++; if (oValid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", oValid); end
    n_checks++; if (oData !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", oData); end
    n_checks++; if (oCount !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", oCount); end
    repeat (5) tick();
    n_checks++; if ((fe_cnt - fe0) != 0 || (ov_cnt - ov0) != 0) begin n_fail++; $display("FAIL single_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", oValid); end
    n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL single_pop_count: got %0d expected 0", oCount); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    iRX = 1'b0;
    repeat (3) tick();
    iRX = 1'b1;
    repeat (30) tick();
    n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", oCount); end
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL glitch_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    send_frame(8'hC3, 1'b1, 1'b0);
    n_checks++; if (oData !== 8'hC3 || oCount !== 3'd1) begin n_fail++; $display("FAIL glitch_next: got %h/%0d expected c3/1", oData, oCount); end
    iReady = 1'b1; tick(); iReady = 1'b0;
  endtask

  task automatic test_framing_error();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (40) tick();
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL framing_pulse: got %0d pulses expected 1", fe_cnt - fe0); end
    n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL framing_count: got %0d expected 0", oCount); end
    iRX = 1'b1;
    repeat (20) tick();
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL framing_hold: got %0d pulses expected 1", fe_cnt - fe0); end
    send_frame(8'h12, 1'b1, 1'b0);
    n_checks++; if (oData !== 8'h12 || oCount !== 3'd1) begin n_fail++; $display("FAIL framing_next: got %h/%0d expected 12/1", oData, oCount); end
    iReady = 1'b1; tick(); iReady = 1'b0;
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    n_checks++; if (oCount !== 3'd4) begin n_fail++; $display("FAIL overrun_count: got %0d expected 4", oCount); end
    n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d pulses expected 1", ov_cnt - ov0); end
    iReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      n_checks++; if (oData !== exp || oValid !== 1'b1) begin n_fail++; $display("FAIL overrun_drain%0d: got %h valid %b expected %h valid 1", i, oData, oValid, exp); end
      tick();
    end
    iReady = 1'b0;
    n_checks++; if (oValid !== 1'b0 || oCount !== 3'd0) begin n_fail++; $display("FAIL overrun_empty: got valid %b count %0d expected 0 0", oValid, oCount); end
  endtask

  task automatic test_full_simultaneous_pop();
    int ov0;
    logic [7:0] exp;
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    n_checks++; if (oCount !== 3'd4) begin n_fail++; $display("FAIL fullpop_prefill: got %0d expected 4", oCount); end
    send_frame(8'h05, 1'b1, 1'b1);
    n_checks++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL fullpop_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    n_checks++; if (oCount !== 3'd4) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 4", oCount); end
    iReady = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      exp = 8'(i);
      n_checks++; if (oData !== exp) begin n_fail++; $display("FAIL fullpop_drain%0d: got %h expected %h", i, oData, exp); end
      tick();
    end
    iReady = 1'b0;
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b expected 0", oValid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h77;
    send_frame(8'h44, 1'b1, 1'b0);
    n_checks++; if (oCount !== 3'd1) begin n_fail++; $display("FAIL midrst_prefill: got %0d expected 1", oCount); end
    iRX = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      iRX = d[i];
      repeat (10) tick();
    end
    iRX = d[3];
    repeat (5) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    iRX = 1'b1;
    n_checks++; if (oValid !== 1'b0 || oCount !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got valid %b count %0d expected 0 0", oValid, oCount); end
    n_checks++; if (oData !== 8'h00 || {oFramingError, oOverrun} !== 2'b00) begin n_fail++; $display("FAIL midrst_outs: got data %h pulses %b expected 00 00", oData, {oFramingError, oOverrun}); end
    repeat (100) tick();
    n_checks++; if (oCount !== 3'd0) begin n_fail++; $display("FAIL midrst_idle: got %0d expected 0", oCount); end
    send_frame(8'h9A, 1'b1, 1'b0);
    n_checks++; if (oData !== 8'h9A || oCount !== 3'd1) begin n_fail++; $display("FAIL midrst_next: got %h/%0d expected 9a/1", oData, oCount); end
    iReady = 1'b1; tick(); iReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_error();
    test_overrun();
    test_full_simultaneous_pop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
